// File: rtl/sum_window_accum.sv
// Window accumulator behind the 8+8->9-bit adder: sums NUM_SAMPLES accepted samples
// and presents each window total on a valid/ready port held until the sink consumes it.
module sum_window_accum #(
  parameter int IN_W        = 9,
  parameter int NUM_SAMPLES = 4,
  parameter int ACC_W       = 11,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  sum_in,
  input  logic             sum_vld,
  output logic             sum_rdy,
  input  logic             clr,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_vld,
  input  logic             acc_rdy,
  output logic [CNT_W-1:0] cnt_o
);

  if (NUM_SAMPLES < 1 || NUM_SAMPLES > 256) begin : g_bad_num_samples
    $error("NUM_SAMPLES must be in 1..256");
  end
  if (ACC_W < IN_W + $clog2(NUM_SAMPLES)) begin : g_bad_acc_w
    $error("ACC_W too narrow for NUM_SAMPLES full-scale samples");
  end
  if (CNT_W < $clog2(NUM_SAMPLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow to count NUM_SAMPLES");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           r_state,   w_state_nxt;
  logic [ACC_W-1:0] r_acc,     w_acc_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [ACC_W-1:0] r_acc_o,   w_acc_o_nxt;
  logic             r_acc_vld, w_acc_vld_nxt;

  logic [ACC_W-1:0] w_sum;
  logic             w_take;
  logic             w_last;

  // Ready never looks at sum_vld, so the upstream adder can't form a combinational loop.
  assign sum_rdy = (r_state == ST_ACCUM) & ~clr & rst;
  assign w_take  = sum_vld & sum_rdy;
  assign w_last  = (r_cnt == LAST_CNT);
  assign w_sum   = r_acc + ACC_W'(sum_in);

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves one unassigned (no latch).
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_acc_o_nxt   = r_acc_o;
    w_acc_vld_nxt = r_acc_vld;
    case (r_state)
      ST_ACCUM: begin
        if (clr) begin
          w_acc_nxt = '0;
          w_cnt_nxt = '0;
        end else if (w_take) begin
          if (w_last) begin
            w_acc_o_nxt   = w_sum;
            w_acc_vld_nxt = 1'b1;
            w_acc_nxt     = '0;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_HOLD;
          end else begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        // clr is deliberately ignored here: a completed total is never discarded.
        if (acc_rdy) begin
          w_acc_vld_nxt = 1'b0;
          w_state_nxt   = ST_ACCUM;
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_acc_o   <= '0;
      r_acc_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_acc_o   <= w_acc_o_nxt;
      r_acc_vld <= w_acc_vld_nxt;
    end
  end

  assign acc_o   = r_acc_o;
  assign acc_vld = r_acc_vld;
  assign cnt_o   = r_cnt;

endmodule

// File: tb/tb_sum_window_accum.sv
// Bench for sum_window_accum: directed window scenarios plus random traffic on a
// 4-sample and a 1-sample instance, each checked every cycle against a running-sum model.
module tb_sum_window_accum;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [8:0] sum_in;
  logic       sum_vld;
  logic       sum_rdy;
  logic [10:0] acc_o;
  logic       acc_vld;
  logic       acc_rdy;
  logic [7:0] cnt_o;

  logic [8:0] sum_in1;
  logic       sum_vld1;
  logic       sum_rdy1;
  logic [8:0] acc_o1;
  logic       acc_vld1;
  logic       acc_rdy1;
  logic [7:0] cnt_o1;

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd     = 0;

  sum_window_accum dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sum_vld(sum_vld), .sum_rdy(sum_rdy),
    .clr(clr), .acc_o(acc_o), .acc_vld(acc_vld), .acc_rdy(acc_rdy), .cnt_o(cnt_o)
  );

  sum_window_accum #(.IN_W(9), .NUM_SAMPLES(1), .ACC_W(9), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .sum_in(sum_in1), .sum_vld(sum_vld1), .sum_rdy(sum_rdy1),
    .clr(1'b0), .acc_o(acc_o1), .acc_vld(acc_vld1), .acc_rdy(acc_rdy1), .cnt_o(cnt_o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: running sum and count of the open window, plus the held total.
  int m_ns   [2] = '{4, 1};
  int m_sum  [2];
  int m_cnt  [2];
  int m_acc  [2];
  bit m_hold [2];
  bit m_vld  [2];

  task automatic model_step(input int k, input bit r, input bit c, input bit v,
                            input int s, input bit ardy);
    if (!r) begin
      m_sum[k] = 0; m_cnt[k] = 0; m_acc[k] = 0; m_hold[k] = 0; m_vld[k] = 0;
    end else if (m_hold[k]) begin
      if (ardy) begin
        m_hold[k] = 0;
        m_vld[k]  = 0;
      end
    end else if (c) begin
      m_sum[k] = 0;
      m_cnt[k] = 0;
    end else if (v) begin
      m_sum[k] += s;
      m_cnt[k] += 1;
      if (m_cnt[k] == m_ns[k]) begin
        m_acc[k]  = m_sum[k];
        m_vld[k]  = 1;
        m_hold[k] = 1;
        m_sum[k]  = 0;
        m_cnt[k]  = 0;
      end
    end
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next edge will see.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_sum[k] = 0; m_cnt[k] = 0; m_acc[k] = 0; m_hold[k] = 0; m_vld[k] = 0;
    end
    forever begin
      @(negedge clk);
      check("m0.acc_vld", 32'(acc_vld), 32'(m_vld[0]));
      check("m0.acc_o",   32'(acc_o),   32'(m_acc[0]));
      check("m0.cnt_o",   32'(cnt_o),   32'(m_cnt[0]));
      check("m0.sum_rdy", 32'(sum_rdy), 32'(rst && !m_hold[0] && !clr));
      check("m1.acc_vld", 32'(acc_vld1), 32'(m_vld[1]));
      check("m1.acc_o",   32'(acc_o1),   32'(m_acc[1]));
      check("m1.cnt_o",   32'(cnt_o1),   32'(m_cnt[1]));
      check("m1.sum_rdy", 32'(sum_rdy1), 32'(rst && !m_hold[1]));
      model_step(0, rst, clr, sum_vld, int'(sum_in), acc_rdy);
      model_step(1, rst, 1'b0, sum_vld1, int'(sum_in1), acc_rdy1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rnd) acc_rdy1 = ~acc_rdy1;
  endtask

  task automatic push(input int v);
    int  n;
    logic took;
    n    = 0;
    took = 1'b0;
    sum_vld = 1'b1;
    sum_in  = 9'(v);
    while (!took && n < 50) begin
      @(negedge clk);
      took = sum_rdy;
      tick();
      n++;
    end
    sum_vld = 1'b0;
    check("push_accepted", 32'(took), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; sum_vld = 1'b0; sum_in = '0; acc_rdy = 1'b1;
    sum_vld1 = 1'b1; sum_in1 = 9'd37; acc_rdy1 = 1'b1;
    tick(); tick();
    rst = 1'b1;

    // T1: back-to-back window
    push(100); push(200); push(300); push(511);
    @(negedge clk);
    check("t1.acc_vld", 32'(acc_vld), 32'd1);
    check("t1.acc_o",   32'(acc_o),   32'd1111);
    check("t1.sum_rdy", 32'(sum_rdy), 32'd0);
    tick();

    // T2: full-scale window, then a small one
    for (int i = 0; i < 4; i++) push(511);
    @(negedge clk);
    check("t2.acc_o_max", 32'(acc_o), 32'd2044);
    tick();
    for (int i = 0; i < 4; i++) push(1);
    @(negedge clk);
    check("t2.acc_o_small", 32'(acc_o), 32'd4);
    tick();

    // T3: sink stalls for 5 cycles while upstream keeps offering data
    acc_rdy = 1'b0;
    push(5); push(6); push(7); push(8);
    sum_vld = 1'b1; sum_in = 9'd400;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3.hold_vld", 32'(acc_vld), 32'd1);
      check("t3.hold_acc", 32'(acc_o),   32'd26);
      check("t3.hold_rdy", 32'(sum_rdy), 32'd0);
      check("t3.hold_cnt", 32'(cnt_o),   32'd0);
      tick();
    end
    sum_vld = 1'b0;
    acc_rdy = 1'b1;
    @(negedge clk);
    check("t3.xfer_vld", 32'(acc_vld), 32'd1);
    tick();
    @(negedge clk);
    check("t3.after_vld", 32'(acc_vld), 32'd0);
    check("t3.after_rdy", 32'(sum_rdy), 32'd1);
    check("t3.after_acc", 32'(acc_o),   32'd26);
    tick();

    // T4: clear discards a partial window and blocks the coincident sample
    push(10); push(20);
    sum_vld = 1'b1; sum_in = 9'd99; clr = 1'b1;
    @(negedge clk);
    check("t4.clr_rdy", 32'(sum_rdy), 32'd0);
    check("t4.pre_cnt", 32'(cnt_o),   32'd2);
    tick();
    clr = 1'b0; sum_vld = 1'b0;
    @(negedge clk);
    check("t4.clr_cnt", 32'(cnt_o), 32'd0);
    tick();
    push(1); push(2); push(3); push(4);
    @(negedge clk);
    check("t4.acc_o", 32'(acc_o), 32'd10);
    tick();

    // T5: reset mid-window and again while holding a total
    push(7); push(8); push(9);
    rst = 1'b0;
    @(negedge clk);
    check("t5.rst_rdy", 32'(sum_rdy), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t5.rst_vld", 32'(acc_vld), 32'd0);
    check("t5.rst_cnt", 32'(cnt_o),   32'd0);
    check("t5.rst_acc", 32'(acc_o),   32'd0);
    tick();
    acc_rdy = 1'b0;
    push(1); push(2); push(3); push(4);
    @(negedge clk);
    check("t5.fresh_acc", 32'(acc_o),   32'd10);
    check("t5.fresh_vld", 32'(acc_vld), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5.hold_vld", 32'(acc_vld), 32'd1);
    tick();
    rst = 1'b1; acc_rdy = 1'b1;
    @(negedge clk);
    check("t5.hrst_vld", 32'(acc_vld), 32'd0);
    check("t5.hrst_acc", 32'(acc_o),   32'd0);
    check("t5.hrst_rdy", 32'(sum_rdy), 32'd1);
    tick();
    push(2); push(3); push(4); push(5);
    @(negedge clk);
    check("t5.new_acc", 32'(acc_o), 32'd14);
    tick();

    // T6: single-sample windows have run throughout with a toggling sink
    @(negedge clk);
    check("t6.acc_o", 32'(acc_o1), 32'd37);
    tick();

    // Random traffic on both instances
    rnd = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      rst      = ($urandom_range(99) != 0);
      clr      = ($urandom_range(15) == 0);
      sum_vld  = ($urandom_range(3) != 0);
      sum_in   = ($urandom_range(3) == 0) ? 9'd511 : 9'($urandom_range(511));
      acc_rdy  = ($urandom_range(3) != 0);
      sum_vld1 = ($urandom_range(3) != 0);
      sum_in1  = 9'($urandom_range(511));
      acc_rdy1 = ($urandom_range(1) != 0);
      tick();
    end
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
